// File: rtl/xif_mem_pkg.sv
// rtl/xif_mem_pkg.sv - shared types and exception codes for the XIF memory/OBI bridge
package xif_mem_pkg;

    localparam int unsigned XIF_ID_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } bridge_state_e;

    localparam logic [5:0] EXC_LD_MISALIGN = 6'd4;
    localparam logic [5:0] EXC_LD_FAULT    = 6'd5;
    localparam logic [5:0] EXC_ST_MISALIGN = 6'd6;
    localparam logic [5:0] EXC_ST_FAULT    = 6'd7;

    typedef struct packed {
        logic [XIF_ID_W-1:0] id;
        logic                we;
    } outstanding_t;

endpackage

// File: rtl/xif_id_fifo.sv
// rtl/xif_id_fifo.sv - synchronous FIFO with occupancy counter tracking outstanding bus transactions
module xif_id_fifo #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    // a pop in the same cycle frees the slot the push needs
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_rdata = r_mem[r_rptr];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/xif_mem_obi_bridge.sv
// rtl/xif_mem_obi_bridge.sv - XIF memory request/result channel to OBI data bus bridge
module xif_mem_obi_bridge
    import xif_mem_pkg::*;
#(
    parameter int unsigned X_ID_WIDTH      = XIF_ID_W,
    parameter int unsigned X_MEM_WIDTH     = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  mem_valid_i,
    output logic                  mem_ready_o,
    input  logic [X_ID_WIDTH-1:0] mem_id_i,
    input  logic [31:0]           mem_addr_i,
    input  logic                  mem_we_i,
    input  logic [2:0]            mem_size_i,
    input  logic [3:0]            mem_be_i,
    input  logic [31:0]           mem_wdata_i,
    output logic                  mem_resp_exc_o,
    output logic [5:0]            mem_resp_exccode_o,
    output logic                  mem_result_valid_o,
    output logic [X_ID_WIDTH-1:0] mem_result_id_o,
    output logic [31:0]           mem_result_rdata_o,
    output logic                  mem_result_err_o,
    output logic                  mem_result_dbg_o,
    output logic                  obi_req_o,
    input  logic                  obi_gnt_i,
    output logic [31:0]           obi_addr_o,
    output logic                  obi_we_o,
    output logic [3:0]            obi_be_o,
    output logic [31:0]           obi_wdata_o,
    input  logic                  obi_rvalid_i,
    input  logic [31:0]           obi_rdata_i,
    input  logic                  obi_err_i
);

    bridge_state_e         r_state;
    bridge_state_e         w_state_next;
    logic [31:0]           r_addr;
    logic                  r_we;
    logic [3:0]            r_be;
    logic [31:0]           r_wdata;
    logic [X_ID_WIDTH-1:0] r_id;
    logic                  r_res_valid;
    logic [X_ID_WIDTH-1:0] r_res_id;
    logic [31:0]           r_res_rdata;
    logic                  r_res_err;
    logic                  w_hs;
    logic                  w_misalign;
    logic                  w_fault;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    outstanding_t          w_push_data;
    outstanding_t          w_head;

    assign mem_ready_o = rst_ni && (r_state == ST_IDLE) && !w_fifo_full;
    assign w_hs        = mem_valid_i && mem_ready_o;
    assign w_misalign  = ((mem_size_i == 3'd1) && mem_addr_i[0]) ||
                         ((mem_size_i == 3'd2) && (mem_addr_i[1:0] != 2'b00));
    assign w_fault     = (mem_size_i > 3'd2);

    always_comb begin
        mem_resp_exc_o     = w_hs && (w_misalign || w_fault);
        mem_resp_exccode_o = 6'd0;
        if (mem_resp_exc_o) begin
            if (w_fault) begin
                mem_resp_exccode_o = mem_we_i ? EXC_ST_FAULT : EXC_LD_FAULT;
            end else begin
                mem_resp_exccode_o = mem_we_i ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
            end
        end
    end

    assign w_accept = w_hs && !mem_resp_exc_o;
    assign w_push   = obi_req_o && obi_gnt_i;
    assign w_pop    = obi_rvalid_i && !w_fifo_empty;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = ST_REQ;
            ST_REQ:  if (obi_gnt_i) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_wdata <= '0;
            r_id    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_addr  <= {mem_addr_i[31:2], 2'b00};
                r_we    <= mem_we_i;
                r_be    <= mem_be_i;
                r_wdata <= mem_wdata_i;
                r_id    <= mem_id_i;
            end
        end
    end

    assign obi_req_o   = (r_state == ST_REQ);
    assign obi_addr_o  = r_addr;
    assign obi_we_o    = r_we;
    assign obi_be_o    = r_be;
    assign obi_wdata_o = r_wdata;

    assign w_push_data.id = XIF_ID_W'(r_id);
    assign w_push_data.we = r_we;

    xif_id_fifo #(
        .WIDTH ($bits(outstanding_t)),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_push),
        .i_wdata (w_push_data),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // stray rvalid with nothing outstanding is swallowed without a result
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_rdata <= '0;
            r_res_err   <= 1'b0;
        end else begin
            r_res_valid <= w_pop;
            r_res_id    <= w_pop ? X_ID_WIDTH'(w_head.id) : '0;
            r_res_rdata <= (w_pop && !w_head.we) ? obi_rdata_i : 32'h0;
            r_res_err   <= w_pop && obi_err_i;
        end
    end

    assign mem_result_valid_o = r_res_valid;
    assign mem_result_id_o    = r_res_id;
    assign mem_result_rdata_o = r_res_rdata;
    assign mem_result_err_o   = r_res_err;
    assign mem_result_dbg_o   = 1'b0;

endmodule
